seq_mul4: RTL and testbench
===========================

Name: seq_mul4

Overview:
- Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH operands, 2*WIDTH-bit product.
- Built around one WIDTH-bit ripple add per cycle. This is the same 4-bit add-with-carry function as the fa4 adders (s, co from a, b, ci), reused iteratively as the consumer stage of the adder.
- Sits between an operand source issuing start pulses and any downstream logic sampling p on done.

Parameters:
- WIDTH, 4, operand width. Product width is 2*WIDTH. Iteration count is WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand; captured on accepted start
- b  input  WIDTH  multiplier; captured on accepted start
- busy  output  1  high whenever state != IDLE
- done  output  1  single-cycle completion pulse
- p  output  2*WIDTH  product register; holds last result

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high. It clears every register immediately, independent of clk.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, p = 0
  - internal M (multiplicand), A (accumulator high), Q (multiplier/low), C (carry), cnt all 0
- State machine:
  - IDLE -> RUN on start=1 at a clock edge.
  - RUN -> RUN while cnt != WIDTH-1.
  - RUN -> DONE on the edge where cnt == WIDTH-1.
  - DONE -> IDLE unconditionally on the next edge.
- Accept (IDLE, start=1): M <= a, Q <= b, A <= 0, C <= 0, cnt <= 0.
- RUN, each edge:
  - {C, A} = Q[0] ? (A + M, ci=0, WIDTH-bit add with carry-out) : {0, A}.
  - Then {C, A, Q} shifts right one bit. C becomes the MSB; C register <= 0.
  - cnt <= cnt + 1.
- RUN -> DONE edge: p <= {A, Q}, using the final shifted values.
- Outputs:
  - done = 1 only in DONE, exactly one cycle per accepted start.
  - busy = 1 in RUN and DONE.
- Latency: start accepted at edge k. done is high in the cycle after edge k+WIDTH (4 cycles for WIDTH=4). Return to IDLE at edge k+WIDTH+1.
- Throughput: one product per WIDTH+2 cycles.
- p changes only on the RUN -> DONE edge. It holds its value through IDLE and through the next operation until that operation completes.
- start while busy (RUN or DONE): ignored. No queuing, no effect on the operation in flight.
- a/b changes after acceptance: no effect, because operands are latched.
- start held high continuously: a new operation is accepted on each IDLE edge, i.e. back-to-back with one IDLE cycle between operations.
- Arithmetic:
  - Unsigned only; the result is exact, so no overflow is possible.
  - Max result is (2^WIDTH - 1)^2 = 225 for WIDTH=4.
  - The internal add carry-out must be kept; dropping it corrupts results with A + M >= 2^WIDTH.
- rst mid-operation: the operation is aborted, no done pulse, p = 0. The next start after rst deasserts proceeds normally.
- Zero operands: still take the full WIDTH cycles; p = 0.

Test Plan:
- Reset: assert rst asynchronously between edges -> busy=0, done=0, p=8'h00 immediately, before the next clk edge.
- a=15, b=15, start one cycle -> busy high next cycle; done high exactly one cycle, 4 cycles after acceptance; p=225 (8'hE1); busy low after done.
- a=0, b=9 then a=9, b=0 -> p=0 both times; each still takes 4 RUN cycles plus 1 DONE cycle.
- a=13, b=11 accepted; during RUN drive a=2, b=2 and pulse start twice -> single done, p=143; p holds 143 until the next completion.
- Start a=7, b=7; assert rst on the 2nd RUN cycle -> no done, p=0, busy=0. Then a=3, b=5 -> p=15.
- Exhaustive: all 256 (a, b) pairs with WIDTH=4, plus 32 $random pairs -> p == a*b at every done. Count done pulses == starts accepted; no done without a preceding accepted start.

Source files
------------

// File: rtl/seq_mul4.sv
// seq_mul4: sequential unsigned shift-and-add multiplier, one ripple add per cycle.
module seq_mul4 #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             r_state;
    logic [WIDTH-1:0]   r_m, r_a, r_q;
    logic               r_c, r_busy, r_done;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH:0]     w_cy;
    logic [WIDTH-1:0]   w_s, w_na, w_nq;
    logic [WIDTH:0]     w_ca;
    logic               w_last;
    assign w_cy[0] = 1'b0;
    for (genvar g = 0; g < WIDTH; g++) begin : g_ripple
        assign w_s[g]      = r_a[g] ^ r_m[g] ^ w_cy[g];
        assign w_cy[g+1]   = (r_a[g] & r_m[g]) | (w_cy[g] & (r_a[g] ^ r_m[g]));
    end
    // carry-out is kept as the bit shifted into the accumulator MSB
    assign w_ca   = r_q[0] ? {w_cy[WIDTH], w_s} : {r_c, r_a};
    assign w_na   = w_ca[WIDTH:1];
    assign w_nq   = {w_ca[0], r_q[WIDTH-1:1]};
    assign w_last = (r_cnt == CW'(WIDTH - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= a;
                        r_q     <= b;
                        r_a     <= '0;
                        r_c     <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= w_na;
                    r_q   <= w_nq;
                    r_c   <= 1'b0;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_p     <= {w_na, w_nq};
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;
endmodule

// File: tb/tb_seq_mul4.sv
// tb_seq_mul4: directed and exhaustive self-checking bench for seq_mul4.
module tb_seq_mul4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       busy, done;
    logic [7:0] p;
    int n_cmp = 0, n_err = 0, n_done = 0, n_exp = 0, lat = 0;

    seq_mul4 #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .p(p)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        lat = 0;
        while (done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp_p);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        wait_done();
        chk("latency", lat, 4);
        chk("product", p, exp_p);
        n_exp++;
        @(negedge clk);
        chk("busy_after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_p", p, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        run_op(4'd15, 4'd15, 8'hE1);
        run_op(4'd0, 4'd9, 8'h00);
        run_op(4'd9, 4'd0, 8'h00);

        // 13x11 with operand changes and extra start pulses while busy
        a = 4'd13; b = 4'd11; start = 1'b1;
        @(negedge clk);
        chk("ign_busy_c0", busy, 1);
        a = 4'd2; b = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_no_early_done", done, 0);
        @(negedge clk);
        chk("ign_done", done, 1);
        chk("ign_product", p, 8'd143);
        n_exp++;
        @(negedge clk);
        chk("ign_idle", {busy, done}, 2'b00);
        repeat (3) @(negedge clk);
        chk("ign_hold_p", p, 8'd143);

        // 7x7 aborted by async reset on the second RUN cycle
        a = 4'd7; b = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_p_held_c0", p, 8'd143);
        @(negedge clk);
        chk("abort_busy_c1", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_p", p, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done", n_done, n_exp);
        run_op(4'd3, 4'd5, 8'd15);

        for (int i = 0; i < 256; i++) begin
            logic [3:0] x, y;
            x = i[7:4];
            y = i[3:0];
            run_op(x, y, 8'(x * y));
        end
        for (int i = 0; i < 32; i++) begin
            logic [3:0] x, y;
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            run_op(x, y, 8'(x * y));
        end

        // start held high: back-to-back with one IDLE cycle between
        a = 4'd6; b = 4'd7; start = 1'b1;
        @(negedge clk);
        chk("held_busy0", busy, 1);
        wait_done();
        chk("held_lat0", lat, 4);
        chk("held_p0", p, 8'd42);
        n_exp++;
        @(negedge clk);
        chk("held_idle", busy, 0);
        a = 4'd5; b = 4'd3;
        @(negedge clk);
        start = 1'b0;
        chk("held_busy1", busy, 1);
        wait_done();
        chk("held_lat1", lat, 4);
        chk("held_p1", p, 8'd15);
        n_exp++;
        @(negedge clk);
        chk("held_end", {busy, done}, 2'b00);
        repeat (3) @(negedge clk);
        chk("done_count", n_done, n_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
